sorted_ram_writer: RTL and testbench

- Write-side companion to the binary-search block.
- Builds and maintains an ascending-sorted 2^ADDR_WIDTH x DATA_WIDTH register memory by insertion sort, one insert per start request, so the sorted image can be searched by the binary-search controller/datapath.
- Uses the same start/done handshake as the search block: s, A in; done, loc out. Adds full/count status and an asynchronous read port for the reader side and for verification.

---
 rtl/sorted_ram_writer_if.sv | 25 ++
 rtl/sorted_ram_writer.sv | 146 ++++++++++++++
 tb/tb_sorted_ram_writer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/sorted_ram_writer_if.sv
// Start/done handshake plus status and asynchronous read port of the
// insertion-sorted register memory.
interface sorted_ram_writer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
);
    logic                  s;
    logic [DATA_WIDTH-1:0] A;
    logic                  done;
    logic                  full;
    logic [ADDR_WIDTH-1:0] loc;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output s, A, rd_addr,
        input  done, full, loc, count, rd_data
    );

    modport slave (
        input  s, A, rd_addr,
        output done, full, loc, count, rd_data
    );
endinterface

// File: rtl/sorted_ram_writer.sv
// Insertion-sort writer: keeps mem[0..count-1] in ascending order, one
// insert per start request, shifting larger entries up one slot per cycle.
module sorted_ram_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                clk,
    input  logic                reset,
    sorted_ram_writer_if.slave  bus
);
    localparam logic [ADDR_WIDTH:0] CAP = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] a_reg;
    logic [ADDR_WIDTH:0]   ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH-1:0] loc;
    logic                  done;
    logic                  full;

    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [ADDR_WIDTH-1:0] prev_idx;
    logic                  is_full;
    logic                  prev_greater;
    logic                  accept;
    logic                  reject;
    logic                  shift_en;
    logic                  write_en;

    // ptr never reaches CAP while inserting, so its low bits address mem.
    assign wr_idx       = ptr[ADDR_WIDTH-1:0];
    assign prev_idx     = wr_idx - ADDR_WIDTH'(1);
    assign is_full      = (count == CAP);
    // Strict compare keeps equal values in arrival order.
    assign prev_greater = (ptr != {(ADDR_WIDTH+1){1'b0}}) && (mem[prev_idx] > a_reg);

    assign bus.done    = done;
    assign bus.full    = full;
    assign bus.loc     = loc;
    assign bus.count   = count;
    assign bus.rd_data = mem[bus.rd_addr];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.s) begin
                    next_state = is_full ? DONE : SHIFT;
                end else begin
                    next_state = IDLE;
                end
            end
            SHIFT: begin
                if (prev_greater) begin
                    next_state = SHIFT;
                end else begin
                    next_state = WRITE;
                end
            end
            WRITE:   next_state = DONE;
            DONE: begin
                if (bus.s) begin
                    next_state = DONE;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath enables decoded from the current state.
    always_comb begin
        accept   = 1'b0;
        reject   = 1'b0;
        shift_en = 1'b0;
        write_en = 1'b0;
        case (state)
            IDLE: begin
                accept = bus.s & ~is_full;
                reject = bus.s & is_full;
            end
            SHIFT:   shift_en = prev_greater;
            WRITE:   write_en = 1'b1;
            DONE:    write_en = 1'b0;
            default: write_en = 1'b0;
        endcase
    end

    // Control/status registers; done is registered so it is high exactly in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg <= {DATA_WIDTH{1'b0}};
            ptr   <= {(ADDR_WIDTH+1){1'b0}};
            count <= {(ADDR_WIDTH+1){1'b0}};
            loc   <= {ADDR_WIDTH{1'b0}};
            full  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= (next_state == DONE);
            if (accept) begin
                a_reg <= bus.A;
                ptr   <= count;
                full  <= 1'b0;
            end else if (reject) begin
                full <= 1'b1;
            end else if (shift_en) begin
                ptr <= ptr - (ADDR_WIDTH+1)'(1);
            end else if (write_en) begin
                loc   <= wr_idx;
                count <= count + (ADDR_WIDTH+1)'(1);
            end
        end
    end

    // Memory array: shift the larger neighbour up, then drop the new value in.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (shift_en) begin
                mem[wr_idx] <= mem[prev_idx];
            end else if (write_en) begin
                mem[wr_idx] <= a_reg;
            end
        end
    end
endmodule

// File: tb/tb_sorted_ram_writer.sv
// Randomized self-checking bench for sorted_ram_writer against a sorted-list model.
module tb_sorted_ram_writer;
    logic clk = 1'b0;
    logic reset = 1'b1;

    sorted_ram_writer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) bus ();

    sorted_ram_writer #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int mdl [0:32];
    int mcount   = 0;
    int last_loc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        bus.s  = 1'b0;
        @(negedge clk);
        check("rst_done",  {31'd0, bus.done}, 32'd0);
        check("rst_full",  {31'd0, bus.full}, 32'd0);
        check("rst_count", {26'd0, bus.count}, 32'd0);
        check("rst_loc",   {27'd0, bus.loc}, 32'd0);
        reset    = 1'b0;
        mcount   = 0;
        last_loc = 0;
    endtask

    // One full handshake; the model decides where the value belongs and how
    // many edges it takes (k entries larger than val => k+3 edges counted
    // from the first edge that sees s=1; a full rejection takes one edge).
    task automatic do_insert(input logic [7:0] val, input int hold);
        int k;
        int exp_lat;
        int exp_loc;
        int exp_full;
        int lat;
        if (mcount == 32) begin
            exp_full = 1;
            exp_lat  = 1;
            exp_loc  = last_loc;
        end else begin
            k = 0;
            for (int i = 0; i < mcount; i++) if (mdl[i] > int'(val)) k++;
            exp_full = 0;
            exp_lat  = k + 3;
            exp_loc  = mcount - k;
            for (int i = mcount; i > exp_loc; i--) mdl[i] = mdl[i-1];
            mdl[exp_loc] = int'(val);
            mcount++;
            last_loc = exp_loc;
        end
        @(negedge clk);
        bus.s = 1'b1;
        bus.A = val;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) bus.A = 8'($urandom);
        end while (!bus.done && lat < 100);
        check("latency", lat, exp_lat);
        check("loc",   {27'd0, bus.loc}, exp_loc);
        check("full",  {31'd0, bus.full}, exp_full);
        check("count", {26'd0, bus.count}, mcount);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_done",  {31'd0, bus.done}, 32'd1);
            check("hold_count", {26'd0, bus.count}, mcount);
        end
        bus.s = 1'b0;
        @(negedge clk);
        check("done_drop", {31'd0, bus.done}, 32'd0);
    endtask

    task automatic readback();
        for (int i = 0; i < mcount; i++) begin
            bus.rd_addr = 5'(i);
            #1;
            check("rd_data", {24'd0, bus.rd_data}, mdl[i]);
        end
    endtask

    initial begin
        bus.s       = 1'b0;
        bus.A       = 8'h00;
        bus.rd_addr = 5'd0;

        // Directed small sequence with duplicates.
        do_reset();
        do_insert(8'h32, 0);
        do_insert(8'h0A, 0);
        do_insert(8'h1E, 0);
        do_insert(8'h1E, 0);
        readback();

        // Fill with descending values, then request past capacity.
        do_reset();
        for (int v = 255; v >= 224; v--) do_insert(8'(v), 0);
        readback();
        do_insert(8'h00, 2);
        readback();

        // Non-full insert after reset, holding s long after done.
        do_reset();
        do_insert(8'h77, 10);

        // Random inserts with duplicates and random hold times.
        do_reset();
        for (int n = 0; n < 24; n++) do_insert(8'($urandom_range(0, 63)), int'($urandom_range(0, 3)));
        readback();

        // Reset while an insert is shifting through a 4-entry memory.
        do_reset();
        do_insert(8'h40, 0);
        do_insert(8'h50, 0);
        do_insert(8'h60, 0);
        do_insert(8'h70, 0);
        @(negedge clk);
        bus.s = 1'b1;
        bus.A = 8'h01;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        bus.s = 1'b0;
        @(negedge clk);
        check("mid_done",  {31'd0, bus.done}, 32'd0);
        check("mid_count", {26'd0, bus.count}, 32'd0);
        check("mid_full",  {31'd0, bus.full}, 32'd0);
        check("mid_loc",   {27'd0, bus.loc}, 32'd0);
        reset    = 1'b0;
        mcount   = 0;
        last_loc = 0;
        do_insert(8'h05, 0);
        readback();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
